// File: rtl/systolic_array_pkg.sv
// systolic_array_pkg: register map, job descriptor and channel states for the matmul dispatcher
package systolic_array_pkg;
   localparam logic [7:0] REG_IN_STAGE   = 8'h00;
   localparam logic [7:0] REG_W_STAGE    = 8'h04;
   localparam logic [7:0] REG_OUT_STAGE  = 8'h08;
   localparam logic [7:0] REG_DOORBELL   = 8'h0C;
   localparam logic [7:0] REG_STATUS     = 8'h10;
   localparam logic [7:0] REG_DONE_COUNT = 8'h14;
   localparam logic [7:0] REG_ERR        = 8'h18;
   typedef struct packed {
      logic [31:0] in_addr;
      logic [31:0] w_addr;
      logic [31:0] out_addr;
   } job_desc_t;
   typedef enum logic [1:0] {CH_IDLE, CH_START, CH_RUN} ch_state_t;
endpackage

// File: rtl/job_fifo.sv
// job_fifo: circular job descriptor queue; a push while full is dropped
module job_fifo
   import systolic_array_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_push,
   input  job_desc_t  i_din,
   input  logic       i_pop,
   output job_desc_t  o_dout,
   output logic       o_full,
   output logic       o_empty,
   output logic [6:0] o_count
);
   localparam int AW = $clog2(DEPTH);
   job_desc_t r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [6:0] r_cnt;
   logic w_push, w_pop;
   assign o_full = r_cnt == 7'(DEPTH);
   assign o_empty = r_cnt == 7'd0;
   assign o_count = r_cnt;
   assign o_dout = r_mem[r_rp];
   assign w_push = i_push && !o_full;
   assign w_pop = i_pop && !o_empty;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp <= '0;
         r_rp <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop) r_rp <= r_rp + AW'(1);
         r_cnt <= r_cnt + 7'(w_push) - 7'(w_pop);
      end
   end
   always_ff @(posedge clk)
      if (w_push) r_mem[r_wp] <= i_din;
endmodule

// File: rtl/matmul_job_dispatcher.sv
// matmul_job_dispatcher: register-mapped job queue feeding NCH systolic-array channels round-robin
module matmul_job_dispatcher
   import systolic_array_pkg::*;
#(
   parameter int NCH   = 2,
   parameter int DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  AWVALID,
   input  logic [31:0]           AWADDR,
   output logic                  AWREADY,
   input  logic                  WDVALID,
   input  logic [31:0]           WDATA,
   output logic                  WDREADY,
   input  logic                  ARVALID,
   input  logic [31:0]           ARADDR,
   output logic                  ARREADY,
   input  logic                  RDREADY,
   output logic                  RDVALID,
   output logic [31:0]           RDATA,
   output logic [NCH-1:0]        start_matmul,
   output logic [NCH-1:0][31:0]  input_addr,
   output logic [NCH-1:0][31:0]  weight_addr,
   output logic [NCH-1:0][31:0]  output_addr,
   input  logic [NCH-1:0]        matmul_finished,
   output logic                  irq
);
   localparam int RW = NCH > 1 ? $clog2(NCH) : 1;
   logic r_aw_held, r_rd_valid;
   logic [7:0] r_aw_addr;
   logic [31:0] r_rdata, r_in, r_w, r_out, r_done;
   logic [1:0] r_err;
   logic [RW-1:0] r_rr;
   ch_state_t r_st [NCH];
   ch_state_t w_st_nx [NCH];
   logic [NCH-1:0][31:0] r_ia, r_wa, r_oa;
   logic w_wr, w_bell, w_full, w_empty, w_disp, w_unused;
   logic [6:0] w_cnt;
   logic [RW-1:0] w_ch;
   logic [NCH-1:0] w_busy, w_fin_ok, w_fin_bad;
   logic [31:0] w_inc, w_status, w_rmux;
   job_desc_t w_head;
   assign w_unused = ^{AWADDR[31:8], ARADDR[31:8], WDATA[31:2]};
   assign AWREADY = !r_aw_held;
   assign WDREADY = r_aw_held;
   assign ARREADY = !r_rd_valid;
   assign RDVALID = r_rd_valid;
   assign RDATA = r_rdata;
   assign irq = r_done != '0;
   assign input_addr = r_ia;
   assign weight_addr = r_wa;
   assign output_addr = r_oa;
   assign w_wr = WDVALID && r_aw_held;
   assign w_bell = w_wr && r_aw_addr == REG_DOORBELL;
   assign w_status = (32'(w_busy) << 10) | {22'd0, w_empty, w_full, 1'b0, w_cnt};
   job_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_bell),
      .i_din   ('{in_addr: r_in, w_addr: r_w, out_addr: r_out}),
      .i_pop   (w_disp),
      .o_dout  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_cnt)
   );
   // descending scan so the idle channel closest to the pointer wins
   always_comb begin
      w_disp = 1'b0;
      w_ch = '0;
      for (int i = NCH - 1; i >= 0; i--)
         if (!w_empty && r_st[(int'(r_rr) + i) % NCH] == CH_IDLE) begin
            w_disp = 1'b1;
            w_ch = RW'((int'(r_rr) + i) % NCH);
         end
   end
   always_comb begin
      w_inc = '0;
      for (int k = 0; k < NCH; k++) begin
         w_busy[k] = r_st[k] != CH_IDLE;
         start_matmul[k] = r_st[k] == CH_START;
         w_fin_ok[k] = matmul_finished[k] && r_st[k] == CH_RUN;
         w_fin_bad[k] = matmul_finished[k] && r_st[k] != CH_RUN;
         w_inc = w_inc + 32'(w_fin_ok[k]);
         w_st_nx[k] = r_st[k] == CH_START ? CH_RUN :
                      w_fin_ok[k] ? CH_IDLE :
                      w_disp && int'(w_ch) == k ? CH_START : r_st[k];
      end
   end
   always_comb begin
      case (ARADDR[7:0])
         REG_IN_STAGE:   w_rmux = r_in;
         REG_W_STAGE:    w_rmux = r_w;
         REG_OUT_STAGE:  w_rmux = r_out;
         REG_STATUS:     w_rmux = w_status;
         REG_DONE_COUNT: w_rmux = r_done;
         REG_ERR:        w_rmux = {30'd0, r_err};
         default:        w_rmux = '0;
      endcase
   end
   always_ff @(posedge clk)
      for (int k = 0; k < NCH; k++) r_st[k] <= rst ? CH_IDLE : w_st_nx[k];
   always_ff @(posedge clk) begin
      if (rst) begin
         r_aw_held <= 1'b0;
         r_aw_addr <= '0;
         r_rd_valid <= 1'b0;
         r_rdata <= '0;
         r_in <= '0;
         r_w <= '0;
         r_out <= '0;
         r_done <= '0;
         r_err <= '0;
         r_rr <= '0;
         r_ia <= '0;
         r_wa <= '0;
         r_oa <= '0;
      end else begin
         if (AWVALID && !r_aw_held) begin
            r_aw_held <= 1'b1;
            r_aw_addr <= AWADDR[7:0];
         end else if (w_wr) r_aw_held <= 1'b0;
         if (w_wr && r_aw_addr == REG_IN_STAGE) r_in <= WDATA;
         if (w_wr && r_aw_addr == REG_W_STAGE) r_w <= WDATA;
         if (w_wr && r_aw_addr == REG_OUT_STAGE) r_out <= WDATA;
         r_done <= (w_wr && r_aw_addr == REG_DONE_COUNT) ? w_inc : r_done + w_inc;
         r_err <= ((w_wr && r_aw_addr == REG_ERR) ? r_err & ~WDATA[1:0] : r_err)
                  | {|w_fin_bad, w_bell && w_full};
         if (ARVALID && !r_rd_valid) begin
            r_rd_valid <= 1'b1;
            r_rdata <= w_rmux;
         end else if (RDREADY) r_rd_valid <= 1'b0;
         if (w_disp) begin
            r_rr <= RW'((int'(w_ch) + 1) % NCH);
            r_ia[w_ch] <= w_head.in_addr;
            r_wa[w_ch] <= w_head.w_addr;
            r_oa[w_ch] <= w_head.out_addr;
         end
      end
   end
endmodule

// File: tb/tb_matmul_job_dispatcher.sv
// tb_matmul_job_dispatcher: directed scenarios plus a randomized job-queue model run
module tb_matmul_job_dispatcher;
   localparam int NCH = 2;
   localparam int DEPTH = 8;
   localparam logic [7:0] A_IN = 8'h00, A_W = 8'h04, A_OUT = 8'h08, A_BELL = 8'h0C;
   localparam logic [7:0] A_STAT = 8'h10, A_DONE = 8'h14, A_ERR = 8'h18;
   logic clk = 1'b0;
   logic rst;
   logic AWVALID, AWREADY, WDVALID, WDREADY, ARVALID, ARREADY, RDREADY, RDVALID, irq;
   logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
   logic [NCH-1:0] start_matmul, matmul_finished;
   logic [NCH-1:0][31:0] input_addr, weight_addr, output_addr;
   int total = 0;
   int bad = 0;
   typedef struct {
      int ch;
      logic [31:0] ia, wa, oa;
   } rec_t;
   rec_t act_q [$];
   rec_t exp_q [$];

   always #5 clk = ~clk;

   matmul_job_dispatcher #(.NCH(NCH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .AWVALID(AWVALID), .AWADDR(AWADDR), .AWREADY(AWREADY),
      .WDVALID(WDVALID), .WDATA(WDATA), .WDREADY(WDREADY),
      .ARVALID(ARVALID), .ARADDR(ARADDR), .ARREADY(ARREADY),
      .RDREADY(RDREADY), .RDVALID(RDVALID), .RDATA(RDATA),
      .start_matmul(start_matmul), .input_addr(input_addr),
      .weight_addr(weight_addr), .output_addr(output_addr),
      .matmul_finished(matmul_finished), .irq(irq)
   );

   always @(negedge clk)
      if (!rst)
         for (int k = 0; k < NCH; k++)
            if (start_matmul[k]) act_q.push_back('{k, input_addr[k], weight_addr[k], output_addr[k]});

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic do_reset;
      rst = 1'b1;
      AWVALID = 0; AWADDR = 0; WDVALID = 0; WDATA = 0;
      ARVALID = 0; ARADDR = 0; RDREADY = 0; matmul_finished = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      act_q.delete();
      exp_q.delete();
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      AWVALID = 1'b1;
      AWADDR = (32'($urandom) & 32'hFFFF_FF00) | {24'd0, a};
      @(posedge clk); #1;
      AWVALID = 1'b0; WDVALID = 1'b1; WDATA = d;
      @(posedge clk); #1;
      WDVALID = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, output logic [31:0] d);
      int n = 0;
      ARVALID = 1'b1;
      ARADDR = (32'($urandom) & 32'hFFFF_FF00) | {24'd0, a};
      @(posedge clk); #1;
      ARVALID = 1'b0;
      while (!RDVALID && n < 10) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (RDVALID !== 1'b1) begin
         bad++;
         $display("FAIL rd_timeout addr=%h rdvalid=%b required 1", a, RDVALID);
      end
      d = RDATA;
      RDREADY = 1'b1;
      @(posedge clk); #1;
      RDREADY = 1'b0;
   endtask

   task automatic bell(input logic [31:0] i, input logic [31:0] w, input logic [31:0] o);
      wr(A_IN, i);
      wr(A_W, w);
      wr(A_OUT, o);
      wr(A_BELL, $urandom);
   endtask

   task automatic fin(input logic [NCH-1:0] m);
      matmul_finished = m;
      @(posedge clk); #1;
      matmul_finished = '0;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      do_reset;
      total++;
      if (AWREADY !== 1 || ARREADY !== 1 || WDREADY !== 0 || RDVALID !== 0) begin
         bad++;
         $display("FAIL reset_handshake aw=%b ar=%b wd=%b rv=%b required 1 1 0 0", AWREADY, ARREADY, WDREADY, RDVALID);
      end
      total++;
      if (start_matmul !== '0 || irq !== 0 || input_addr !== '0) begin
         bad++;
         $display("FAIL reset_outputs start=%b irq=%b ia=%h required 0", start_matmul, irq, input_addr);
      end
      rd(A_STAT, d);
      total++;
      if (d !== 32'h200) begin bad++; $display("FAIL reset_status got=%h required 200", d); end
      rd(A_DONE, d);
      total++;
      if (d !== 0) begin bad++; $display("FAIL reset_done got=%h required 0", d); end
      AWVALID = 1'b1; AWADDR = {24'd0, A_ERR};
      @(posedge clk); #1;
      AWVALID = 1'b0;
      total++;
      if (WDREADY !== 1 || AWREADY !== 0) begin
         bad++;
         $display("FAIL aw_held wdready=%b awready=%b required 1 0", WDREADY, AWREADY);
      end
      WDVALID = 1'b1; WDATA = 0;
      @(posedge clk); #1;
      WDVALID = 1'b0;
      fin(2'b01);
      rd(A_ERR, d);
      total++;
      if (d !== 32'h2) begin bad++; $display("FAIL spurious_err got=%h required 2", d); end
      wr(A_ERR, 32'h2);
      rd(A_ERR, d);
      total++;
      if (d !== 0 || irq !== 0) begin bad++; $display("FAIL err_w1c got=%h irq=%b required 0 0", d, irq); end
   endtask

   task automatic test_basic;
      logic [31:0] d;
      do_reset;
      bell(32'h100, 32'h200, 32'h300);
      settle(3);
      total++;
      if (act_q.size() != 1) begin
         bad++;
         $display("FAIL basic_starts count=%0d required 1", act_q.size());
      end else if (act_q[0].ch != 0 || act_q[0].ia !== 32'h100 || act_q[0].wa !== 32'h200 || act_q[0].oa !== 32'h300) begin
         bad++;
         $display("FAIL basic_job ch=%0d %h/%h/%h required 0 100/200/300", act_q[0].ch, act_q[0].ia, act_q[0].wa, act_q[0].oa);
      end
      settle(4);
      total++;
      if (input_addr[0] !== 32'h100 || weight_addr[0] !== 32'h200 || output_addr[0] !== 32'h300 || start_matmul !== 0) begin
         bad++;
         $display("FAIL basic_hold ia=%h wa=%h oa=%h start=%b required 100 200 300 0", input_addr[0], weight_addr[0], output_addr[0], start_matmul);
      end
      rd(A_W, d);
      total++;
      if (d !== 32'h200) begin bad++; $display("FAIL rd_wstage got=%h required 200", d); end
      rd(A_BELL, d);
      total++;
      if (d !== 0) begin bad++; $display("FAIL rd_doorbell got=%h required 0", d); end
      wr(8'h40, 32'hDEAD);
      rd(8'h40, d);
      total++;
      if (d !== 0) begin bad++; $display("FAIL rd_unmapped got=%h required 0", d); end
   endtask

   task automatic test_two_channels;
      logic [31:0] d;
      do_reset;
      bell(32'hA0, 32'hA1, 32'hA2);
      bell(32'hB0, 32'hB1, 32'hB2);
      bell(32'hC0, 32'hC1, 32'hC2);
      settle(3);
      total++;
      if (act_q.size() != 2 || act_q[0].ch != 0 || act_q[0].ia !== 32'hA0 || act_q[1].ch != 1 || act_q[1].ia !== 32'hB0) begin
         bad++;
         $display("FAIL two_ch_first count=%0d required 2 jobs A0 on ch0, B0 on ch1", act_q.size());
      end
      rd(A_STAT, d);
      total++;
      if (d !== 32'hC01) begin bad++; $display("FAIL two_ch_status got=%h required c01", d); end
      fin(2'b01);
      settle(3);
      total++;
      if (act_q.size() != 3 || act_q[2].ch != 0 || act_q[2].ia !== 32'hC0 || act_q[2].oa !== 32'hC2) begin
         bad++;
         $display("FAIL two_ch_third count=%0d required 3 with C0 on ch0", act_q.size());
      end
      rd(A_DONE, d);
      total++;
      if (d !== 1 || irq !== 1) begin bad++; $display("FAIL two_ch_done got=%h irq=%b required 1 1", d, irq); end
   endtask

   task automatic test_overflow;
      logic [31:0] d;
      do_reset;
      repeat (DEPTH + NCH + 1) bell($urandom, $urandom, $urandom);
      settle(3);
      rd(A_STAT, d);
      total++;
      if (d !== (((32'd1 << NCH) - 1) << 10 | 32'h100 | DEPTH)) begin
         bad++;
         $display("FAIL ovf_status got=%h required %h", d, ((32'd1 << NCH) - 1) << 10 | 32'h100 | DEPTH);
      end
      rd(A_ERR, d);
      total++;
      if (d !== 32'h1) begin bad++; $display("FAIL ovf_err got=%h required 1", d); end
      wr(A_ERR, 32'h1);
      rd(A_ERR, d);
      total++;
      if (d !== 0) begin bad++; $display("FAIL ovf_w1c got=%h required 0", d); end
   endtask

   task automatic test_done_clear;
      logic [31:0] d;
      do_reset;
      bell(1, 2, 3);
      bell(4, 5, 6);
      settle(3);
      fin(2'b11);
      rd(A_DONE, d);
      total++;
      if (d !== 2) begin bad++; $display("FAIL done_pair got=%h required 2", d); end
      bell(7, 8, 9);
      bell(10, 11, 12);
      settle(3);
      AWVALID = 1'b1; AWADDR = {24'd0, A_DONE};
      @(posedge clk); #1;
      AWVALID = 1'b0; WDVALID = 1'b1; WDATA = $urandom; matmul_finished = 2'b11;
      @(posedge clk); #1;
      WDVALID = 1'b0; matmul_finished = '0;
      rd(A_DONE, d);
      total++;
      if (d !== 2 || irq !== 1) begin bad++; $display("FAIL done_clear_inc got=%h irq=%b required 2 1", d, irq); end
      wr(A_DONE, 0);
      rd(A_DONE, d);
      total++;
      if (d !== 0 || irq !== 0) begin bad++; $display("FAIL done_clear got=%h irq=%b required 0 0", d, irq); end
   endtask

   task automatic test_read_hold;
      logic [31:0] x;
      do_reset;
      x = $urandom;
      wr(A_OUT, x);
      ARVALID = 1'b1; ARADDR = {24'd0, A_OUT};
      @(posedge clk); #1;
      ARADDR = {24'd0, A_STAT};
      for (int c = 0; c < 5; c++) begin
         total++;
         if (RDVALID !== 1 || RDATA !== x || ARREADY !== 0) begin
            bad++;
            $display("FAIL rd_hold cyc=%0d rv=%b rdata=%h ar=%b required 1 %h 0", c, RDVALID, RDATA, ARREADY, x);
         end
         @(posedge clk); #1;
      end
      ARVALID = 1'b0; RDREADY = 1'b1;
      @(posedge clk); #1;
      RDREADY = 1'b0;
      total++;
      if (RDVALID !== 0 || ARREADY !== 1) begin
         bad++;
         $display("FAIL rd_release rv=%b ar=%b required 0 1", RDVALID, ARREADY);
      end
   endtask

   task automatic test_rst_run;
      logic [31:0] d;
      do_reset;
      bell(1, 2, 3);
      bell(4, 5, 6);
      settle(3);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      total++;
      if (start_matmul !== 0 || irq !== 0 || output_addr !== '0) begin
         bad++;
         $display("FAIL rst_run_outputs start=%b irq=%b oa=%h required 0", start_matmul, irq, output_addr);
      end
      rd(A_STAT, d);
      total++;
      if (d !== 32'h200) begin bad++; $display("FAIL rst_run_status got=%h required 200", d); end
      fin(2'b01);
      rd(A_ERR, d);
      total++;
      if (d !== 32'h2) begin bad++; $display("FAIL rst_run_abandon got=%h required 2", d); end
   endtask

   task automatic test_random;
      logic [95:0] q [$];
      logic [95:0] j;
      logic [NCH-1:0] busy, m;
      logic [31:0] d, ia, wa, oa, est;
      int rr = 0, done = 0, err = 0, k, found;
      do_reset;
      busy = '0;
      for (int it = 0; it < 60; it++) begin
         if (busy == '0 || $urandom_range(0, 9) < 6) begin
            ia = $urandom; wa = $urandom; oa = $urandom;
            bell(ia, wa, oa);
            if (q.size() < DEPTH) q.push_back({ia, wa, oa});
            else err = 1;
         end else begin
            k = $urandom_range(0, NCH - 1);
            while (!busy[k]) k = (k + 1) % NCH;
            m = '0; m[k] = 1'b1;
            fin(m);
            busy[k] = 1'b0;
            done++;
         end
         while (q.size() > 0) begin
            found = -1;
            for (int i = 0; i < NCH; i++)
               if (found < 0 && !busy[(rr + i) % NCH]) found = (rr + i) % NCH;
            if (found < 0) break;
            j = q.pop_front();
            busy[found] = 1'b1;
            rr = (found + 1) % NCH;
            exp_q.push_back('{found, j[95:64], j[63:32], j[31:0]});
         end
         settle(3);
         total++;
         if (act_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL rand_start_count it=%0d got=%0d required %0d", it, act_q.size(), exp_q.size());
         end
         while (act_q.size() > 0 && exp_q.size() > 0) begin
            rec_t a, e;
            a = act_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (a.ch != e.ch || a.ia !== e.ia || a.wa !== e.wa || a.oa !== e.oa) begin
               bad++;
               $display("FAIL rand_job it=%0d ch=%0d %h/%h/%h required ch=%0d %h/%h/%h", it, a.ch, a.ia, a.wa, a.oa, e.ch, e.ia, e.wa, e.oa);
            end
         end
         act_q.delete();
         exp_q.delete();
         est = (32'(busy) << 10) | (q.size() == 0 ? 32'h200 : 0) | (q.size() == DEPTH ? 32'h100 : 0) | 32'(q.size());
         rd(A_STAT, d);
         total++;
         if (d !== est || irq !== (done != 0)) begin
            bad++;
            $display("FAIL rand_status it=%0d got=%h irq=%b required %h %b", it, d, irq, est, done != 0);
         end
      end
      rd(A_DONE, d);
      total++;
      if (d !== 32'(done)) begin bad++; $display("FAIL rand_done got=%0d required %0d", d, done); end
      rd(A_ERR, d);
      total++;
      if (d !== 32'(err)) begin bad++; $display("FAIL rand_err got=%h required %h", d, err); end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_two_channels;
      test_overflow;
      test_done_clear;
      test_read_hold;
      test_rst_run;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/matmul_job_dispatcher.md
MATMUL_JOB_DISPATCHER -- requirements
Module: matmul_job_dispatcher

Interface
REQ-001 SHALL have parameter NCH, default 2, meaning number of systolic-array channels served (1..8).
REQ-002 SHALL have parameter DEPTH, default 8, meaning job FIFO entries (power of two, 2..64).
REQ-003 SHALL have port clk  input  1  the single clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports AWVALID/AWADDR/AWREADY  in/in/out  1/32/1  write-address channel.
REQ-006 SHALL have ports WDVALID/WDATA/WDREADY  in/in/out  1/32/1  write-data channel.
REQ-007 SHALL have ports ARVALID/ARADDR/ARREADY  in/in/out  1/32/1  read-address channel.
REQ-008 SHALL have ports RDREADY/RDVALID/RDATA  in/out/out  1/1/32  read-data channel.
REQ-009 SHALL have port start_matmul  output  [NCH-1:0]  one-cycle start pulse per channel.
REQ-010 SHALL have ports input_addr/weight_addr/output_addr  output  [NCH-1:0][31:0]  per-channel job addresses.
REQ-011 SHALL have port matmul_finished  input  [NCH-1:0]  one-cycle completion pulse per channel.
REQ-012 SHALL have port irq  output  1  high while DONE_COUNT is non-zero.

Function
REQ-013 SHALL decode AWADDR[7:0]/ARADDR[7:0]: 0x00 IN_STAGE, 0x04 W_STAGE, 0x08 OUT_STAGE (RW), 0x0C DOORBELL (W, reads 0), 0x10 STATUS (RO), 0x14 DONE_COUNT (any write clears), 0x18 ERR (W1C); unmapped reads return 0, unmapped writes are ignored.
REQ-014 SHALL assert AWREADY when no write address is held; AWVALID&&AWREADY latches the address.
REQ-015 SHALL assert WDREADY only while a write address is held; WDVALID&&WDREADY commits the write and frees the address in the same cycle.
REQ-016 SHALL assert ARREADY when no read is pending; RDATA is registered, RDVALID rises the cycle after acceptance, and both hold until RDREADY.
REQ-017 SHALL push {IN_STAGE, W_STAGE, OUT_STAGE} into the FIFO on a DOORBELL write; on a full FIFO the push is dropped and ERR[0] (overflow) is set. Fullness is evaluated before any same-cycle pop.
REQ-018 SHALL encode STATUS as [6:0] occupancy, [8] full, [9] empty, [10+k] channel k busy.
REQ-019 SHALL give each channel an FSM: IDLE -> START (start_matmul[k]=1 for exactly one cycle, addresses loaded) -> RUN -> IDLE on matmul_finished[k].
REQ-020 SHALL hold input_addr/weight_addr/output_addr[k] stable from START until the next dispatch to channel k.
REQ-021 SHALL dispatch at most one job per cycle, from a non-empty FIFO, to the first IDLE channel at or after the round-robin pointer; the pointer then advances to that channel+1 modulo NCH.
REQ-022 SHALL ignore matmul_finished[k] while channel k is IDLE or in START, and set ERR[1] (spurious finish) when this happens.
REQ-023 SHALL increment the 32-bit DONE_COUNT once per accepted finish, summing simultaneous finishes from several channels in one cycle, and wrap at 2^32.
REQ-024 SHALL apply a clear of DONE_COUNT on the same cycle as increments so that the result equals the increments counted in that cycle.
REQ-025 SHALL give a same-cycle DOORBELL push to an empty FIFO a dispatch no earlier than the following cycle.

Reset
REQ-026 SHALL on rst clear the FIFO, staging registers, DONE_COUNT, ERR, RR pointer, and held read/write addresses.
REQ-027 SHALL on rst drive all channels IDLE and all outputs 0 (AWREADY=1, ARREADY=1, WDREADY=0, RDVALID=0); jobs in flight mid-operation are abandoned.

Structure
REQ-028 SHALL place the register offsets and a job_desc_t struct (three 32-bit words) in systolic_array_pkg.
REQ-029 SHALL implement the FIFO as sub-module job_fifo (parameter DEPTH, push/pop/full/empty/count).

Verification
REQ-030 SHALL cover: write 0x100/0x200/0x300 to 0x00/0x04/0x08, then doorbell -> start_matmul[0] pulse, with addresses 0x100/0x200/0x300.
REQ-031 SHALL cover: three doorbells with NCH=2 -> jobs on ch0, then ch1; the third dispatches only after the first finish.
REQ-032 SHALL cover: DEPTH+1 doorbells with channels stalled -> STATUS full=1, occupancy=DEPTH, ERR=0x1.
REQ-033 SHALL cover: finish on ch0 and ch1 in the same cycle as a DONE_COUNT clear -> DONE_COUNT=2, irq=1.
REQ-034 SHALL cover: RDREADY held low 5 cycles -> RDVALID/RDATA stable; ARREADY=0 until RDREADY.
REQ-035 SHALL cover: rst asserted during RUN -> all channels IDLE, STATUS=0x200 next cycle.
